// File: rtl/codec_config_sequencer.sv
// WM8731 bring-up sequencer: walks the fixed register table through i2c_controller
// with NACK retries and inter-transfer gaps, then serves single runtime writes.
module codec_config_sequencer #(
    parameter logic [7:0]  DEV_ADDR     = 8'h34,
    parameter int          MAX_RETRY    = 3,
    parameter logic [15:0] PWRUP_CYCLES = 16'd50000,
    parameter logic [7:0]  GAP_CYCLES   = 8'd200
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [23:0] i2c_data,
    output logic        i2c_start,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    input  logic        wr_req,
    input  logic [15:0] wr_word,
    output logic        wr_ack,
    output logic        busy,
    output logic        config_done,
    output logic        config_error
);

    localparam int GAP_W   = (GAP_CYCLES > 8'd1) ? $clog2(GAP_CYCLES) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [15:0]        PWR_LAST  = (PWRUP_CYCLES > 16'd0) ? PWRUP_CYCLES - 16'd1 : 16'd0;
    localparam logic [GAP_W-1:0]   GAP_LAST  = (GAP_CYCLES > 8'd0) ? GAP_W'(GAP_CYCLES - 8'd1) : '0;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [1:0]         GUARD_LAST = 2'd2;
    localparam logic [3:0]         LAST_IDX   = 4'd10;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_CHECK,
        ST_GAP,
        ST_READY
    } state_t;

    state_t               state;
    logic [15:0]          pwr_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [1:0]           guard_cnt;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [3:0]           idx;
    logic [15:0]          rt_word;
    logic                 rt_pending;
    logic                 retry_pending;
    logic                 fail_flag;
    logic                 ack_q;

    logic pwr_last;
    logic gap_last;

    assign pwr_last = (pwr_cnt >= PWR_LAST);
    assign gap_last = (gap_cnt >= GAP_LAST);

    function automatic logic [15:0] rom_word(input logic [3:0] i);
        case (i)
            4'd0:    rom_word = 16'h1E00;
            4'd1:    rom_word = 16'h0017;
            4'd2:    rom_word = 16'h0217;
            4'd3:    rom_word = 16'h0479;
            4'd4:    rom_word = 16'h0679;
            4'd5:    rom_word = 16'h0812;
            4'd6:    rom_word = 16'h0A00;
            4'd7:    rom_word = 16'h0C00;
            4'd8:    rom_word = 16'h0E42;
            4'd9:    rom_word = 16'h1000;
            default: rom_word = 16'h1201;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_PWRUP;
            i2c_data      <= 24'h000000;
            i2c_start     <= 1'b0;
            wr_ack        <= 1'b0;
            busy          <= 1'b1;
            config_done   <= 1'b0;
            config_error  <= 1'b0;
            pwr_cnt       <= '0;
            gap_cnt       <= '0;
            guard_cnt     <= '0;
            retry_cnt     <= '0;
            idx           <= '0;
            rt_word       <= '0;
            rt_pending    <= 1'b0;
            retry_pending <= 1'b0;
            fail_flag     <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            i2c_start <= 1'b0;
            wr_ack    <= 1'b0;

            case (state)
                ST_PWRUP: begin
                    if (pwr_last) begin
                        idx   <= '0;
                        state <= ST_LOAD;
                    end else begin
                        pwr_cnt <= pwr_cnt + 16'd1;
                    end
                end

                // i2c_data is updated only here, so it holds through START and WAIT
                ST_LOAD: begin
                    i2c_data  <= {DEV_ADDR, rt_pending ? rt_word : rom_word(idx)};
                    i2c_start <= 1'b1;
                    state     <= ST_START;
                end

                ST_START: begin
                    guard_cnt <= '0;
                    state     <= ST_WAIT;
                end

                // The controller's done may still be high from the previous transfer
                // until its stage counter clears, so the first two cycles are blind.
                ST_WAIT: begin
                    if (guard_cnt < GUARD_LAST) begin
                        guard_cnt <= guard_cnt + 2'd1;
                    end else if (i2c_done) begin
                        ack_q <= i2c_ack;
                        state <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    gap_cnt <= '0;
                    state   <= ST_GAP;
                    if (ack_q) begin
                        retry_cnt     <= '0;
                        retry_pending <= 1'b0;
                    end else if (retry_cnt != RETRY_MAX) begin
                        retry_cnt     <= retry_cnt + RETRY_W'(1);
                        retry_pending <= 1'b1;
                    end else begin
                        retry_cnt     <= '0;
                        retry_pending <= 1'b0;
                        // a failed runtime write is reported only through wr_ack
                        if (!rt_pending) begin
                            config_error <= 1'b1;
                            fail_flag    <= 1'b1;
                        end
                    end
                end

                ST_GAP: begin
                    if (!gap_last) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end else if (retry_pending) begin
                        retry_pending <= 1'b0;
                        state         <= ST_LOAD;
                    end else if (rt_pending) begin
                        rt_pending <= 1'b0;
                        wr_ack     <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_READY;
                    end else if (idx < LAST_IDX) begin
                        idx   <= idx + 4'd1;
                        state <= ST_LOAD;
                    end else begin
                        if (!fail_flag) begin
                            config_done <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= ST_READY;
                    end
                end

                ST_READY: begin
                    // the requester still holds wr_req during the wr_ack cycle
                    if (wr_req && !wr_ack) begin
                        rt_word    <= wr_word;
                        rt_pending <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end

                default: begin
                    state <= ST_PWRUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: randomized I2C slave responses, scoreboard of
// expected transfer words built from the register table and per-entry NACK plans.
module tb_codec_config_sequencer;

    localparam int MAX_RETRY = 3;
    localparam int PWRUP     = 20;
    localparam int GAP       = 4;

    localparam logic [15:0] ROM [11] = '{
        16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
        16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] i2c_data;
    logic        i2c_start;
    logic        i2c_done;
    logic        i2c_ack;
    logic        wr_req;
    logic [15:0] wr_word;
    logic        wr_ack;
    logic        busy;
    logic        config_done;
    logic        config_error;

    always #5 clk = ~clk;

    codec_config_sequencer #(
        .DEV_ADDR    (8'h34),
        .MAX_RETRY   (MAX_RETRY),
        .PWRUP_CYCLES(16'(PWRUP)),
        .GAP_CYCLES  (8'(GAP))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i2c_data    (i2c_data),
        .i2c_start   (i2c_start),
        .i2c_done    (i2c_done),
        .i2c_ack     (i2c_ack),
        .wr_req      (wr_req),
        .wr_word     (wr_word),
        .wr_ack      (wr_ack),
        .busy        (busy),
        .config_done (config_done),
        .config_error(config_error)
    );

    typedef struct {
        logic [23:0] data;
        bit          timed;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_starts = 0;
    int   cyc      = 0;
    int   done_cyc = -1000;
    int   nack_left [11];
    int   rt_nack_left = 0;
    bit   rt_phase = 1'b0;
    bit   sticky   = 1'b0;
    bit   exp_done = 1'b0;
    bit   exp_err  = 1'b0;
    int   exp_starts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // I2C slave: done may stay high (stale) until three cycles after the next start
    initial begin
        logic [15:0] w;
        bit          s_ack;
        int          lat;
        i2c_done = 1'b0;
        i2c_ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_start === 1'b1) begin
                w     = i2c_data[15:0];
                s_ack = 1'b1;
                if (rt_phase) begin
                    if (rt_nack_left > 0) begin
                        s_ack = 1'b0;
                        rt_nack_left--;
                    end
                end else begin
                    for (int e = 0; e < 11; e++) begin
                        if (ROM[e] == w && nack_left[e] > 0) begin
                            s_ack = 1'b0;
                            nack_left[e]--;
                        end
                    end
                end
                lat = $urandom_range(1, 6);
                for (int k = 0; k < 3 + lat; k++) begin
                    @(negedge clk);
                    if (k == 2) begin
                        i2c_done = 1'b0;
                        i2c_ack  = 1'b0;
                    end
                    check("start_during_open_transfer", 32'(i2c_start), 0);
                end
                i2c_done = 1'b1;
                i2c_ack  = s_ack;
                done_cyc = cyc;
                if (!sticky) begin
                    @(negedge clk);
                    i2c_done = 1'b0;
                    i2c_ack  = 1'b0;
                end
            end
        end
    end

    // Monitor: pops one expectation per start strobe
    initial begin
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (i2c_start === 1'b1) begin
                n_starts++;
                check("start_single_cycle", 32'(prev), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_start: got i2c_data 0x%06h, required no transfer", i2c_data);
                end else begin
                    e = exp_q.pop_front();
                    check("i2c_data", 32'(i2c_data), 32'(e.data));
                    if (e.timed) check("done_to_start_cycles", cyc - done_cyc, GAP + 3);
                end
            end
            prev = i2c_start;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_i2c_data"},     32'(i2c_data), 0);
        check({tag, "_i2c_start"},    32'(i2c_start), 0);
        check({tag, "_wr_ack"},       32'(wr_ack), 0);
        check({tag, "_busy"},         32'(busy), 1);
        check({tag, "_config_done"},  32'(config_done), 0);
        check({tag, "_config_error"}, 32'(config_error), 0);
    endtask

    task automatic begin_bringup(input int plan[11], input bit stk);
        exp_t ent;
        int   att;
        @(negedge clk);
        rst_n  = 1'b0;
        wr_req = 1'b0;
        #1;
        check_reset_outputs("reset");
        exp_q.delete();
        rt_phase   = 1'b0;
        sticky     = stk;
        exp_err    = 1'b0;
        exp_starts = 0;
        for (int e = 0; e < 11; e++) begin
            nack_left[e] = plan[e];
            att = (plan[e] <= MAX_RETRY) ? plan[e] + 1 : MAX_RETRY + 1;
            if (plan[e] > MAX_RETRY) exp_err = 1'b1;
            for (int a = 0; a < att; a++) begin
                ent.data  = {8'h34, ROM[e]};
                ent.timed = !(e == 0 && a == 0);
                exp_q.push_back(ent);
                exp_starts++;
            end
        end
        exp_done = !exp_err;
        repeat (3) @(negedge clk);
        n_starts = 0;
        rst_n    = 1'b1;
    endtask

    task automatic finish_bringup();
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check("bringup_within_budget", 32'(i < 4000), 1);
        check("bringup_queue_drained", exp_q.size(), 0);
        check("bringup_start_count", n_starts, exp_starts);
        check("config_done", 32'(config_done), 32'(exp_done));
        check("config_error", 32'(config_error), 32'(exp_err));
    endtask

    task automatic rt_write(input logic [15:0] w, input int nacks, input bit pre);
        exp_t ent;
        int   att;
        int   i;
        att          = (nacks <= MAX_RETRY) ? nacks + 1 : MAX_RETRY + 1;
        rt_nack_left = nacks;
        rt_phase     = 1'b1;
        n_starts     = 0;
        for (int a = 0; a < att; a++) begin
            ent.data  = {8'h34, w};
            ent.timed = (a > 0);
            exp_q.push_back(ent);
        end
        if (!pre) begin
            wr_word = w;
            wr_req  = 1'b1;
        end
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wr_ack === 1'b1) break;
        end
        check("wr_ack_within_budget", 32'(i < 2000), 1);
        check("rt_busy_low_with_ack", 32'(busy), 0);
        check("rt_queue_drained", exp_q.size(), 0);
        check("rt_start_count", n_starts, att);
        check("rt_config_done", 32'(config_done), 32'(exp_done));
        check("rt_config_error", 32'(config_error), 32'(exp_err));
        wr_req = 1'b0;
        @(negedge clk);
        check("wr_ack_single_cycle", 32'(wr_ack), 0);
        repeat (8) @(negedge clk);
        check("rt_stays_ready", 32'(busy), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int clean[11];
        int plan[11];
        int i;
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        wr_word = 16'h0000;
        clean   = '{default: 0};

        // Clean bring-up; a runtime request raised early must wait for READY
        begin_bringup(clean, 1'b0);
        repeat (5) @(negedge clk);
        wr_word = 16'h0460;
        wr_req  = 1'b1;
        finish_bringup();
        rt_write(16'h0460, 0, 1'b1);
        rt_write(16'($urandom_range(0, 65535)), $urandom_range(0, 5), 1'b0);

        // Entry 3 NACKed twice, stale done held high
        plan    = clean;
        plan[3] = 2;
        begin_bringup(plan, 1'b1);
        finish_bringup();

        // Entry 5 never ACKed
        plan    = clean;
        plan[5] = 99;
        begin_bringup(plan, 1'b0);
        finish_bringup();
        rt_write(16'h0460, 0, 1'b0);
        rt_write(16'($urandom_range(0, 65535)), 9, 1'b0);

        // Reset during the WAIT of entry 4, then a full restart
        begin_bringup(clean, 1'b1);
        for (i = 0; i < 3000 && n_starts < 5; i++) @(negedge clk);
        check("reached_entry4", n_starts, 5);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_wait_reset");
        begin_bringup(clean, 1'b1);
        finish_bringup();

        // Random NACK plans and runtime writes
        for (int r = 0; r < 3; r++) begin
            for (int e = 0; e < 11; e++) begin
                plan[e] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            end
            begin_bringup(plan, 1'($urandom_range(0, 1)));
            finish_bringup();
            rt_write(16'($urandom_range(0, 65535)), $urandom_range(0, 5), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
